// File: rtl/alu_share_if.sv
// Command/response bundle for the shared 4-bit ALU controller.
// master = requesters plus response consumer, slave = the controller.
interface alu_share_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_carry;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_y, rsp_carry, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_y, rsp_carry, rsp_id
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one ALU; one command in flight at a time,
// result returned registered and tagged with the issuing requester id.
module alu_share_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          FIX_PRIO = 1'b0
) (
  input logic        clk,
  input logic        rst,
  alu_share_if.slave bus
);

  if (WIDTH != 4) begin : g_width_chk
    $error("alu_share_ctrl: WIDTH must be 4");
  end

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_id_q, rsp_id_d;
  logic             gnt0, gnt1;
  logic [WIDTH:0]   alu_res;

  // Grant is only offered in idle; on a tie round-robin flips last_grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (FIX_PRIO || last_grant_q) gnt0 = 1'b1;
        else                          gnt1 = 1'b1;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  // Top bit carries the add carry or the subtract borrow.
  always_comb begin
    alu_res = '0;
    case (sel_q)
      3'b000:  alu_res = {1'b0, a_q} + {1'b0, b_q};
      3'b001:  alu_res = {1'b0, a_q} - {1'b0, b_q};
      3'b010:  alu_res = {1'b0, a_q & b_q};
      3'b011:  alu_res = {1'b0, a_q | b_q};
      3'b100:  alu_res = {1'b0, a_q ^ b_q};
      3'b101:  alu_res = {1'b0, ~a_q};
      3'b110:  alu_res = {1'b0, b_q[WIDTH-2:0], 1'b0};
      default: alu_res = {2'b00, b_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_y_d      = rsp_y_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_id_d     = rsp_id_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          a_d          = gnt1 ? bus.req1_a   : bus.req0_a;
          b_d          = gnt1 ? bus.req1_b   : bus.req0_b;
          sel_d        = gnt1 ? bus.req1_sel : bus.req0_sel;
          id_d         = gnt1;
          last_grant_d = gnt1;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_y_d     = alu_res[WIDTH-1:0];
        rsp_carry_d = alu_res[WIDTH];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_y_q      <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_y_q      <= rsp_y_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: instance 0 round-robin, instance 1 fixed priority,
// both checked every cycle against a transaction-level reference model.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v[2][2];
  logic [3:0] a[2][2], b[2][2];
  logic [2:0] s[2][2];
  logic       rr[2];
  logic       rdy[2][2];
  logic       rv[2], rc[2], rid[2];
  logic [3:0] ry[2];

  alu_share_if #(.WIDTH(4)) bus[2] ();

  for (genvar k = 0; k < 2; k++) begin : g_dut
    assign bus[k].req0_valid = v[k][0];
    assign bus[k].req0_a     = a[k][0];
    assign bus[k].req0_b     = b[k][0];
    assign bus[k].req0_sel   = s[k][0];
    assign bus[k].req1_valid = v[k][1];
    assign bus[k].req1_a     = a[k][1];
    assign bus[k].req1_b     = b[k][1];
    assign bus[k].req1_sel   = s[k][1];
    assign bus[k].rsp_ready  = rr[k];
    assign rdy[k][0]         = bus[k].req0_ready;
    assign rdy[k][1]         = bus[k].req1_ready;
    assign rv[k]             = bus[k].rsp_valid;
    assign ry[k]             = bus[k].rsp_y;
    assign rc[k]             = bus[k].rsp_carry;
    assign rid[k]            = bus[k].rsp_id;

    alu_share_ctrl #(.WIDTH(4), .FIX_PRIO(k == 1)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[k])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the op table using plain integer arithmetic.
  function automatic void alu_ref(input int ai, input int bi, input int sel,
                                  output int y, output int c);
    c = 0;
    case (sel)
      0: begin y = (ai + bi) % 16; c = (ai + bi > 15) ? 1 : 0; end
      1: begin y = (ai - bi + 16) % 16; c = (ai < bi) ? 1 : 0; end
      2: y = ai & bi;
      3: y = ai | bi;
      4: y = ai ^ bi;
      5: y = 15 - ai;
      6: y = (bi * 2) % 16;
      default: y = bi / 2;
    endcase
  endfunction

  // Model state (written only by the model process).
  bit         pend[2];
  int         cnt[2];
  bit         last[2];
  int         ey[2], ec[2], eid[2];
  int         hs_cnt[2][2];

  // Driver state.
  int         hs_seen[2][2];
  bit         issuing[2][2];
  int         iss_done[2][2];
  // Main-process controls.
  int         iss_req[2][2];
  int         ca[2][2], cb[2][2], cs[2][2];
  int         mode[2][2];
  int         rr_mode[2];

  always @(negedge clk) begin
    bit ev, any;
    int w, yy, cc;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        cnt[k]  = 0;
        last[k] = 1'b1;
        check_eq($sformatf("rst_valid%0d", k), rv[k], 0);
        check_eq($sformatf("rst_y%0d", k), ry[k], 0);
        check_eq($sformatf("rst_carry%0d", k), rc[k], 0);
        check_eq($sformatf("rst_id%0d", k), rid[k], 0);
      end else begin
        if (pend[k]) cnt[k]++;
        ev = pend[k] && cnt[k] >= 2;
        check_eq($sformatf("rsp_valid%0d", k), rv[k], ev);
        if (ev) begin
          check_eq($sformatf("rsp_y%0d", k), ry[k], ey[k]);
          check_eq($sformatf("rsp_carry%0d", k), rc[k], ec[k]);
          check_eq($sformatf("rsp_id%0d", k), rid[k], eid[k]);
        end
        any = 1'b0;
        w   = 0;
        if (!pend[k]) begin
          any = v[k][0] || v[k][1];
          if (v[k][0] && v[k][1]) w = (k == 1) ? 0 : (last[k] ? 0 : 1);
          else                    w = v[k][1] ? 1 : 0;
        end
        check_eq($sformatf("ready0_%0d", k), rdy[k][0], any && w == 0);
        check_eq($sformatf("ready1_%0d", k), rdy[k][1], any && w == 1);
        if (any) begin
          pend[k] = 1'b1;
          cnt[k]  = 0;
          last[k] = w[0];
          alu_ref(a[k][w], b[k][w], s[k][w], yy, cc);
          ey[k]  = yy;
          ec[k]  = cc;
          eid[k] = w;
          hs_cnt[k][w]++;
        end else if (ev && rr[k]) begin
          pend[k] = 1'b0;
        end
      end
    end
  end

  // Requester/consumer driver: holds each command until its handshake.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 2; r++) begin
          if (rst) begin
            v[k][r]       = 1'b0;
            hs_seen[k][r] = hs_cnt[k][r];
            if (issuing[k][r]) begin
              issuing[k][r]  = 1'b0;
              iss_done[k][r] = iss_req[k][r];
            end
          end else begin
            if (v[k][r] && hs_seen[k][r] != hs_cnt[k][r]) begin
              v[k][r]       = 1'b0;
              hs_seen[k][r] = hs_cnt[k][r];
              if (issuing[k][r]) begin
                issuing[k][r]  = 1'b0;
                iss_done[k][r] = iss_req[k][r];
              end
            end
            if (!v[k][r]) begin
              if (iss_done[k][r] != iss_req[k][r]) begin
                v[k][r]       = 1'b1;
                a[k][r]       = ca[k][r][3:0];
                b[k][r]       = cb[k][r][3:0];
                s[k][r]       = cs[k][r][2:0];
                issuing[k][r] = 1'b1;
              end else if (mode[k][r] == 2 || (mode[k][r] == 1 && $urandom_range(0, 2) == 0)) begin
                v[k][r] = 1'b1;
                a[k][r] = 4'($urandom_range(0, 15));
                b[k][r] = 4'($urandom_range(0, 15));
                s[k][r] = 3'($urandom_range(0, 7));
              end
            end
          end
        end
        rr[k] = (rr_mode[k] == 1) ? 1'b1 : (rr_mode[k] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic post(input int k, input int r, input int ia, input int ib, input int isel);
    ca[k][r] = ia;
    cb[k][r] = ib;
    cs[k][r] = isel;
    iss_req[k][r]++;
  endtask

  task automatic wait_issue(input int k, input int r);
    for (int n = 0; n < 50 && iss_done[k][r] != iss_req[k][r]; n++) begin
      @(posedge clk);
      #2;
    end
    check_eq($sformatf("issue_done%0d_%0d", k, r), iss_done[k][r], iss_req[k][r]);
  endtask

  task automatic issue(input int k, input int r, input int ia, input int ib, input int isel);
    post(k, r, ia, ib, isel);
    wait_issue(k, r);
  endtask

  // Called right after an accept: the response must show on the second falling edge.
  task automatic expect_rsp(input string tag, input int k, input int y, input int c, input int id);
    int n;
    @(negedge clk);
    n = 1;
    while (!rv[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_lat"}, n, 2);
    check_eq({tag, "_y"}, ry[k], y);
    check_eq({tag, "_carry"}, rc[k], c);
    check_eq({tag, "_id"}, rid[k], id);
  endtask

  initial begin
    int prev_id, prev_t, t, got, g, seen;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rr[k] = 1'b0;
      rr_mode[k] = 1;
      for (int r = 0; r < 2; r++) begin
        v[k][r] = 1'b0; a[k][r] = '0; b[k][r] = '0; s[k][r] = '0;
        mode[k][r] = 0;
      end
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    issue(0, 0, 9, 8, 0);
    expect_rsp("t1", 0, 1, 1, 0);
    issue(0, 1, 3, 5, 1);
    expect_rsp("t2a", 0, 'hE, 1, 1);
    issue(0, 0, 5, 3, 1);
    expect_rsp("t2b", 0, 2, 0, 0);

    // Continuous contention under round-robin.
    mode[0][0] = 2;
    mode[0][1] = 2;
    prev_id = -1; prev_t = 0; t = 0; got = 0;
    while (got < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (rv[0] && rr[0]) begin
        if (prev_id >= 0) begin
          check_eq("t3_alt", rid[0], (prev_id == 0) ? 1 : 0);
          check_eq("t3_gap", t - prev_t, 3);
        end
        prev_id = rid[0];
        prev_t  = t;
        got++;
      end
    end
    check_eq("t3_count", got, 4);
    mode[0][0] = 0;
    mode[0][1] = 0;
    repeat (8) @(posedge clk);
    #2;

    // Back-pressure: result held, queued request not accepted.
    rr_mode[0] = 0;
    issue(0, 1, 7, 'hB, 6);
    expect_rsp("t4", 0, 6, 0, 1);
    post(0, 0, 4, 4, 2);
    repeat (5) begin
      @(negedge clk);
      check_eq("t4_hold_y", ry[0], 6);
      check_eq("t4_hold_valid", rv[0], 1);
      check_eq("t4_no_ready", rdy[0][0], 0);
    end
    rr_mode[0] = 1;
    wait_issue(0, 0);
    expect_rsp("t4b", 0, 4, 0, 0);

    // Reset while executing discards the command.
    issue(0, 0, 2, 2, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("t5_no_stale", rv[0], 0);
    end
    issue(0, 0, 'hF, 1, 0);
    expect_rsp("t5", 0, 0, 1, 0);

    // Fixed priority instance.
    mode[1][0] = 2;
    mode[1][1] = 2;
    g = 0;
    repeat (24) begin
      @(negedge clk);
      g += int'(rdy[1][1]);
    end
    check_eq("t6_no_gnt1", g, 0);
    mode[1][0] = 0;
    seen = 0;
    for (int n = 0; n < 12 && seen == 0; n++) begin
      @(negedge clk);
      if (rdy[1][1]) seen = 1;
    end
    check_eq("t6_gnt1", seen, 1);
    mode[1][1] = 0;
    repeat (8) @(posedge clk);
    #2;

    // Random traffic on both instances with occasional resets.
    for (int k = 0; k < 2; k++) begin
      rr_mode[k] = 2;
      mode[k][0] = 1;
      mode[k][1] = 1;
    end
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #2;
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rr_mode[k] = 1;
      mode[k][0] = 0;
      mode[k][1] = 0;
    end
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
